// File: rtl/lotr_pkg.sv
// Shared ring field widths, opcode encoding and packet payload for the LOTR ring fabric.
package lotr_pkg;

  localparam int unsigned REQUESTOR_W = 10;
  localparam int unsigned ADDR_W      = 32;
  localparam int unsigned DATA_W      = 32;
  localparam int unsigned ID_W        = 8;
  localparam int unsigned PERF_W      = 16;

  typedef enum logic [1:0] {
    RD     = 2'd0,
    WR     = 2'd1,
    RD_RSP = 2'd2,
    WR_RSP = 2'd3
  } t_opcode;

  typedef struct packed {
    logic [REQUESTOR_W-1:0] requestor;
    t_opcode                opcode;
    logic [ADDR_W-1:0]      address;
    logic [DATA_W-1:0]      data;
  } t_ring_pkt;

  localparam int unsigned PKT_W = $bits(t_ring_pkt);

  // Requests are routed by the tile ID in the top address byte.
  function automatic logic req_targets(input t_ring_pkt pkt, input logic [ID_W-1:0] id);
    return pkt.address[ADDR_W-1 -: ID_W] == id;
  endfunction

  // Responses return to the tile encoded in the upper requestor bits.
  function automatic logic rsp_targets(input t_ring_pkt pkt, input logic [ID_W-1:0] id);
    return pkt.requestor[REQUESTOR_W-1 -: ID_W] == id;
  endfunction

endpackage

// File: rtl/ring_stop_fifo.sv
// Power-of-two injection FIFO: valid/ready push side, pop strobe on the head.
// A pop in the same cycle frees a slot, so a full FIFO still accepts a push.
module ring_stop_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_valid,
  output logic             push_ready_c,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             head_valid_c,
  output logic [WIDTH-1:0] head_data_c
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign head_valid_c = (count != '0);
  assign head_data_c  = mem[rd_ptr];
  assign full         = (count == CNT_W'(DEPTH));
  assign do_pop       = pop && head_valid_c;
  assign push_ready_c = !full || do_pop;
  assign do_push      = push_valid && push_ready_c;

  // Storage needs no reset: entries are only read while count says they are live.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/ring_stop.sv
// Ring stop: two-stage request/response ring slots with local ejection and FIFO-backed injection.
// Optional RING_STOP_PERF_EN adds saturating forward/inject/eject slot counters.
module ring_stop
  import lotr_pkg::*;
#(
  parameter int unsigned INJ_DEPTH = 4
) (
  input  logic                   QClk,
  input  logic                   RstQnnnL,
  input  logic [ID_W-1:0]        CoreID,

  input  logic                   RingReqInValidQ500H,
  input  logic [REQUESTOR_W-1:0] RingReqInRequestorQ500H,
  input  t_opcode                RingReqInOpcodeQ500H,
  input  logic [ADDR_W-1:0]      RingReqInAddressQ500H,
  input  logic [DATA_W-1:0]      RingReqInDataQ500H,

  input  logic                   RingRspInValidQ500H,
  input  logic [REQUESTOR_W-1:0] RingRspInRequestorQ500H,
  input  t_opcode                RingRspInOpcodeQ500H,
  input  logic [ADDR_W-1:0]      RingRspInAddressQ500H,
  input  logic [DATA_W-1:0]      RingRspInDataQ500H,

  output logic                   RingReqOutValidQ502H,
  output logic [REQUESTOR_W-1:0] RingReqOutRequestorQ502H,
  output t_opcode                RingReqOutOpcodeQ502H,
  output logic [ADDR_W-1:0]      RingReqOutAddressQ502H,
  output logic [DATA_W-1:0]      RingReqOutDataQ502H,

  output logic                   RingRspOutValidQ502H,
  output logic [REQUESTOR_W-1:0] RingRspOutRequestorQ502H,
  output t_opcode                RingRspOutOpcodeQ502H,
  output logic [ADDR_W-1:0]      RingRspOutAddressQ502H,
  output logic [DATA_W-1:0]      RingRspOutDataQ502H,

  input  logic                   CoreReqValid,
  input  logic [REQUESTOR_W-1:0] CoreReqRequestor,
  input  t_opcode                CoreReqOpcode,
  input  logic [ADDR_W-1:0]      CoreReqAddress,
  input  logic [DATA_W-1:0]      CoreReqData,
  output logic                   CoreReqReady,

  input  logic                   TgtRspValid,
  input  logic [REQUESTOR_W-1:0] TgtRspRequestor,
  input  t_opcode                TgtRspOpcode,
  input  logic [ADDR_W-1:0]      TgtRspAddress,
  input  logic [DATA_W-1:0]      TgtRspData,
  output logic                   TgtRspReady,

  output logic                   EjReqValidQ502H,
  output logic [REQUESTOR_W-1:0] EjReqRequestorQ502H,
  output t_opcode                EjReqOpcodeQ502H,
  output logic [ADDR_W-1:0]      EjReqAddressQ502H,
  output logic [DATA_W-1:0]      EjReqDataQ502H,

  output logic                   EjRspValidQ502H,
  output logic [REQUESTOR_W-1:0] EjRspRequestorQ502H,
  output t_opcode                EjRspOpcodeQ502H,
  output logic [ADDR_W-1:0]      EjRspAddressQ502H,
  output logic [DATA_W-1:0]      EjRspDataQ502H
`ifdef RING_STOP_PERF_EN
  ,
  output logic [PERF_W-1:0]      PerfFwdCnt,
  output logic [PERF_W-1:0]      PerfInjCnt,
  output logic [PERF_W-1:0]      PerfEjCnt
`endif
);

  t_ring_pkt req_in_pkt;
  t_ring_pkt rsp_in_pkt;
  t_ring_pkt core_pkt;
  t_ring_pkt tgt_pkt;

  assign req_in_pkt = '{requestor: RingReqInRequestorQ500H, opcode: RingReqInOpcodeQ500H,
                        address: RingReqInAddressQ500H, data: RingReqInDataQ500H};
  assign rsp_in_pkt = '{requestor: RingRspInRequestorQ500H, opcode: RingRspInOpcodeQ500H,
                        address: RingRspInAddressQ500H, data: RingRspInDataQ500H};
  assign core_pkt   = '{requestor: CoreReqRequestor, opcode: CoreReqOpcode,
                        address: CoreReqAddress, data: CoreReqData};
  assign tgt_pkt    = '{requestor: TgtRspRequestor, opcode: TgtRspOpcode,
                        address: TgtRspAddress, data: TgtRspData};

  // Injection ports stay closed during reset and for the first cycle after release.
  logic inj_en;

  always_ff @(posedge QClk or negedge RstQnnnL) begin
    if (!RstQnnnL) begin
      inj_en <= 1'b0;
    end else begin
      inj_en <= 1'b1;
    end
  end

  // Q501 slot registers
  logic      req_v1;
  logic      rsp_v1;
  t_ring_pkt req_p1;
  t_ring_pkt rsp_p1;

  always_ff @(posedge QClk or negedge RstQnnnL) begin
    if (!RstQnnnL) begin
      req_v1 <= 1'b0;
      rsp_v1 <= 1'b0;
      req_p1 <= '0;
      rsp_p1 <= '0;
    end else begin
      req_v1 <= RingReqInValidQ500H;
      rsp_v1 <= RingRspInValidQ500H;
      req_p1 <= req_in_pkt;
      rsp_p1 <= rsp_in_pkt;
    end
  end

  logic      req_fifo_ready_c;
  logic      rsp_fifo_ready_c;
  logic      req_head_valid_c;
  logic      rsp_head_valid_c;
  t_ring_pkt req_head_c;
  t_ring_pkt rsp_head_c;
  logic      req_ej_c;
  logic      rsp_ej_c;
  logic      req_fwd_c;
  logic      rsp_fwd_c;
  logic      req_inj_c;
  logic      rsp_inj_c;

  // Slot decision: eject if addressed here, else forward; a free or freed slot takes the FIFO head.
  always_comb begin
    req_ej_c  = 1'b0;
    rsp_ej_c  = 1'b0;
    req_fwd_c = 1'b0;
    rsp_fwd_c = 1'b0;
    if (req_v1) begin
      req_ej_c  = req_targets(req_p1, CoreID);
      req_fwd_c = !req_ej_c;
    end
    if (rsp_v1) begin
      rsp_ej_c  = rsp_targets(rsp_p1, CoreID);
      rsp_fwd_c = !rsp_ej_c;
    end
    req_inj_c = !req_fwd_c && req_head_valid_c;
    rsp_inj_c = !rsp_fwd_c && rsp_head_valid_c;
  end

  ring_stop_fifo #(
    .DEPTH (INJ_DEPTH),
    .WIDTH (PKT_W)
  ) u_req_fifo (
    .clk          (QClk),
    .rst_n        (RstQnnnL),
    .push_valid   (CoreReqValid && inj_en),
    .push_ready_c (req_fifo_ready_c),
    .push_data    (core_pkt),
    .pop          (req_inj_c),
    .head_valid_c (req_head_valid_c),
    .head_data_c  (req_head_c)
  );

  ring_stop_fifo #(
    .DEPTH (INJ_DEPTH),
    .WIDTH (PKT_W)
  ) u_rsp_fifo (
    .clk          (QClk),
    .rst_n        (RstQnnnL),
    .push_valid   (TgtRspValid && inj_en),
    .push_ready_c (rsp_fifo_ready_c),
    .push_data    (tgt_pkt),
    .pop          (rsp_inj_c),
    .head_valid_c (rsp_head_valid_c),
    .head_data_c  (rsp_head_c)
  );

  assign CoreReqReady = inj_en && req_fifo_ready_c;
  assign TgtRspReady  = inj_en && rsp_fifo_ready_c;

  // Q502 output registers; empty slots carry all-zero fields.
  logic      req_out_v;
  logic      rsp_out_v;
  logic      ej_req_v;
  logic      ej_rsp_v;
  t_ring_pkt req_out_p;
  t_ring_pkt rsp_out_p;
  t_ring_pkt ej_req_p;
  t_ring_pkt ej_rsp_p;

  always_ff @(posedge QClk or negedge RstQnnnL) begin
    if (!RstQnnnL) begin
      req_out_v <= 1'b0;
      rsp_out_v <= 1'b0;
      ej_req_v  <= 1'b0;
      ej_rsp_v  <= 1'b0;
      req_out_p <= '0;
      rsp_out_p <= '0;
      ej_req_p  <= '0;
      ej_rsp_p  <= '0;
    end else begin
      req_out_v <= req_fwd_c || req_inj_c;
      rsp_out_v <= rsp_fwd_c || rsp_inj_c;
      ej_req_v  <= req_ej_c;
      ej_rsp_v  <= rsp_ej_c;
      req_out_p <= req_fwd_c ? req_p1 : (req_inj_c ? req_head_c : '0);
      rsp_out_p <= rsp_fwd_c ? rsp_p1 : (rsp_inj_c ? rsp_head_c : '0);
      ej_req_p  <= req_ej_c ? req_p1 : '0;
      ej_rsp_p  <= rsp_ej_c ? rsp_p1 : '0;
    end
  end

  assign RingReqOutValidQ502H     = req_out_v;
  assign RingReqOutRequestorQ502H = req_out_p.requestor;
  assign RingReqOutOpcodeQ502H    = req_out_p.opcode;
  assign RingReqOutAddressQ502H   = req_out_p.address;
  assign RingReqOutDataQ502H      = req_out_p.data;

  assign RingRspOutValidQ502H     = rsp_out_v;
  assign RingRspOutRequestorQ502H = rsp_out_p.requestor;
  assign RingRspOutOpcodeQ502H    = rsp_out_p.opcode;
  assign RingRspOutAddressQ502H   = rsp_out_p.address;
  assign RingRspOutDataQ502H      = rsp_out_p.data;

  assign EjReqValidQ502H          = ej_req_v;
  assign EjReqRequestorQ502H      = ej_req_p.requestor;
  assign EjReqOpcodeQ502H         = ej_req_p.opcode;
  assign EjReqAddressQ502H        = ej_req_p.address;
  assign EjReqDataQ502H           = ej_req_p.data;

  assign EjRspValidQ502H          = ej_rsp_v;
  assign EjRspRequestorQ502H      = ej_rsp_p.requestor;
  assign EjRspOpcodeQ502H         = ej_rsp_p.opcode;
  assign EjRspAddressQ502H        = ej_rsp_p.address;
  assign EjRspDataQ502H           = ej_rsp_p.data;

`ifdef RING_STOP_PERF_EN
  logic [PERF_W-1:0] fwd_cnt;
  logic [PERF_W-1:0] inj_cnt;
  logic [PERF_W-1:0] ej_cnt;

  // Up to two events per cycle (one per ring); saturate instead of wrapping.
  function automatic logic [PERF_W-1:0] sat_add(input logic [PERF_W-1:0] cnt, input logic [1:0] inc);
    logic [PERF_W:0] sum;
    sum = {1'b0, cnt} + (PERF_W+1)'(inc);
    return sum[PERF_W] ? {PERF_W{1'b1}} : sum[PERF_W-1:0];
  endfunction

  always_ff @(posedge QClk or negedge RstQnnnL) begin
    if (!RstQnnnL) begin
      fwd_cnt <= '0;
      inj_cnt <= '0;
      ej_cnt  <= '0;
    end else begin
      fwd_cnt <= sat_add(fwd_cnt, 2'(req_fwd_c) + 2'(rsp_fwd_c));
      inj_cnt <= sat_add(inj_cnt, 2'(req_inj_c) + 2'(rsp_inj_c));
      ej_cnt  <= sat_add(ej_cnt,  2'(req_ej_c)  + 2'(rsp_ej_c));
    end
  end

  assign PerfFwdCnt = fwd_cnt;
  assign PerfInjCnt = inj_cnt;
  assign PerfEjCnt  = ej_cnt;
`endif

endmodule

// File: tb/tb_ring_stop.sv
// Self-checking bench for ring_stop: directed scenarios plus randomized traffic against a queue-based slot model.
module tb_ring_stop;
  import lotr_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam logic [7:0]  CORE_ID = 8'd2;

  typedef struct packed {
    logic      v;
    t_ring_pkt p;
  } slot_t;

  logic QClk = 1'b0;
  logic RstQnnnL;
  always #5 QClk = ~QClk;

  slot_t in_req, in_rsp, core_req, tgt_rsp;

  logic                   rqo_v, rso_v, ejq_v, ejs_v;
  logic [REQUESTOR_W-1:0] rqo_rq, rso_rq, ejq_rq, ejs_rq;
  t_opcode                rqo_op, rso_op, ejq_op, ejs_op;
  logic [ADDR_W-1:0]      rqo_ad, rso_ad, ejq_ad, ejs_ad;
  logic [DATA_W-1:0]      rqo_dt, rso_dt, ejq_dt, ejs_dt;
  logic                   core_rdy, tgt_rdy;
`ifdef RING_STOP_PERF_EN
  logic [15:0]            perf_fwd, perf_inj, perf_ej;
`endif

  ring_stop #(.INJ_DEPTH(DEPTH)) dut (
    .QClk(QClk), .RstQnnnL(RstQnnnL), .CoreID(CORE_ID),
    .RingReqInValidQ500H(in_req.v), .RingReqInRequestorQ500H(in_req.p.requestor),
    .RingReqInOpcodeQ500H(in_req.p.opcode), .RingReqInAddressQ500H(in_req.p.address),
    .RingReqInDataQ500H(in_req.p.data),
    .RingRspInValidQ500H(in_rsp.v), .RingRspInRequestorQ500H(in_rsp.p.requestor),
    .RingRspInOpcodeQ500H(in_rsp.p.opcode), .RingRspInAddressQ500H(in_rsp.p.address),
    .RingRspInDataQ500H(in_rsp.p.data),
    .RingReqOutValidQ502H(rqo_v), .RingReqOutRequestorQ502H(rqo_rq), .RingReqOutOpcodeQ502H(rqo_op),
    .RingReqOutAddressQ502H(rqo_ad), .RingReqOutDataQ502H(rqo_dt),
    .RingRspOutValidQ502H(rso_v), .RingRspOutRequestorQ502H(rso_rq), .RingRspOutOpcodeQ502H(rso_op),
    .RingRspOutAddressQ502H(rso_ad), .RingRspOutDataQ502H(rso_dt),
    .CoreReqValid(core_req.v), .CoreReqRequestor(core_req.p.requestor), .CoreReqOpcode(core_req.p.opcode),
    .CoreReqAddress(core_req.p.address), .CoreReqData(core_req.p.data), .CoreReqReady(core_rdy),
    .TgtRspValid(tgt_rsp.v), .TgtRspRequestor(tgt_rsp.p.requestor), .TgtRspOpcode(tgt_rsp.p.opcode),
    .TgtRspAddress(tgt_rsp.p.address), .TgtRspData(tgt_rsp.p.data), .TgtRspReady(tgt_rdy),
    .EjReqValidQ502H(ejq_v), .EjReqRequestorQ502H(ejq_rq), .EjReqOpcodeQ502H(ejq_op),
    .EjReqAddressQ502H(ejq_ad), .EjReqDataQ502H(ejq_dt),
    .EjRspValidQ502H(ejs_v), .EjRspRequestorQ502H(ejs_rq), .EjRspOpcodeQ502H(ejs_op),
    .EjRspAddressQ502H(ejs_ad), .EjRspDataQ502H(ejs_dt)
`ifdef RING_STOP_PERF_EN
    , .PerfFwdCnt(perf_fwd), .PerfInjCnt(perf_inj), .PerfEjCnt(perf_ej)
`endif
  );

  int checks = 0;
  int fails  = 0;

  // Reference model: slot seen at the stop last edge, injection queues, expected Q502 outputs.
  slot_t     m_req_s1, m_rsp_s1;
  slot_t     exp_req_out, exp_rsp_out, exp_ej_req, exp_ej_rsp;
  t_ring_pkt m_reqq[$];
  t_ring_pkt m_rspq[$];
  logic      m_en;

  task automatic chk_slot(input string tag, input slot_t obs, input slot_t exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic req_hit(input slot_t s);
    return s.v && (s.p.address[31:24] == CORE_ID);
  endfunction

  function automatic logic rsp_hit(input slot_t s);
    return s.v && (s.p.requestor[9:2] == CORE_ID);
  endfunction

  // A push is taken if there is room, or if the head leaves this cycle through a free/freed slot.
  function automatic logic exp_req_ready();
    logic slot_taken;
    slot_taken = m_req_s1.v && !req_hit(m_req_s1);
    return m_en && ((m_reqq.size() < DEPTH) || (m_reqq.size() != 0 && !slot_taken));
  endfunction

  function automatic logic exp_rsp_ready();
    logic slot_taken;
    slot_taken = m_rsp_s1.v && !rsp_hit(m_rsp_s1);
    return m_en && ((m_rspq.size() < DEPTH) || (m_rspq.size() != 0 && !slot_taken));
  endfunction

  task automatic model_clear();
    m_reqq.delete();
    m_rspq.delete();
    m_req_s1 = '0; m_rsp_s1 = '0;
    exp_req_out = '0; exp_rsp_out = '0; exp_ej_req = '0; exp_ej_rsp = '0;
    m_en = 1'b0;
  endtask

  task automatic model_edge();
    logic rq_rdy, rs_rdy;
    rq_rdy = exp_req_ready();
    rs_rdy = exp_rsp_ready();
    exp_ej_req = req_hit(m_req_s1) ? m_req_s1 : '0;
    if (m_req_s1.v && !req_hit(m_req_s1)) exp_req_out = m_req_s1;
    else if (m_reqq.size() != 0) exp_req_out = {1'b1, m_reqq.pop_front()};
    else exp_req_out = '0;
    exp_ej_rsp = rsp_hit(m_rsp_s1) ? m_rsp_s1 : '0;
    if (m_rsp_s1.v && !rsp_hit(m_rsp_s1)) exp_rsp_out = m_rsp_s1;
    else if (m_rspq.size() != 0) exp_rsp_out = {1'b1, m_rspq.pop_front()};
    else exp_rsp_out = '0;
    if (core_req.v && rq_rdy) m_reqq.push_back(core_req.p);
    if (tgt_rsp.v && rs_rdy) m_rspq.push_back(tgt_rsp.p);
    m_req_s1 = in_req;
    m_rsp_s1 = in_rsp;
    m_en = 1'b1;
  endtask

  task automatic check_outputs();
    chk_slot("ring_req_out", {rqo_v, rqo_rq, rqo_op, rqo_ad, rqo_dt}, exp_req_out);
    chk_slot("ring_rsp_out", {rso_v, rso_rq, rso_op, rso_ad, rso_dt}, exp_rsp_out);
    chk_slot("ej_req",       {ejq_v, ejq_rq, ejq_op, ejq_ad, ejq_dt}, exp_ej_req);
    chk_slot("ej_rsp",       {ejs_v, ejs_rq, ejs_op, ejs_ad, ejs_dt}, exp_ej_rsp);
    chk_val("core_req_ready", 32'(core_rdy), 32'(exp_req_ready()));
    chk_val("tgt_rsp_ready",  32'(tgt_rdy),  32'(exp_rsp_ready()));
  endtask

  // Called at a falling edge with inputs already driven; returns at the next falling edge.
  task automatic step();
    check_outputs();
    model_edge();
    @(posedge QClk);
    @(negedge QClk);
  endtask

  task automatic apply_reset();
    RstQnnnL = 1'b0;
    #1;
    model_clear();
    check_outputs();
    in_req = '0; in_rsp = '0; core_req = '0; tgt_rsp = '0;
    repeat (2) @(negedge QClk);
    RstQnnnL = 1'b1;
  endtask

  function automatic slot_t mk(input logic v, input logic [9:0] rq, input t_opcode op,
                               input logic [31:0] ad, input logic [31:0] dt);
    slot_t s;
    s.v = v; s.p.requestor = rq; s.p.opcode = op; s.p.address = ad; s.p.data = dt;
    return s;
  endfunction

  function automatic slot_t rand_slot(input logic is_rsp, input int unsigned pct);
    slot_t      s;
    logic [7:0] tgt;
    case ($urandom_range(0, 2))
      0:       tgt = CORE_ID;
      1:       tgt = 8'h03;
      default: tgt = 8'($urandom);
    endcase
    s.v = ($urandom_range(0, 99) < pct);
    s.p.requestor = 10'($urandom);
    s.p.opcode = t_opcode'($urandom_range(0, 3));
    s.p.address = $urandom;
    s.p.data = $urandom;
    if (is_rsp) s.p.requestor[9:2] = tgt;
    else s.p.address[31:24] = tgt;
    return s;
  endfunction

  initial begin
    RstQnnnL = 1'b1;
    in_req = '0; in_rsp = '0; core_req = '0; tgt_rsp = '0;
    model_clear();
    #2;
    apply_reset();

    // Own-tile request is ejected, its ring slot leaves empty
    in_req = mk(1'b1, 10'h0AB, WR, 32'h0200_0010, 32'hDEAD_BEEF);
    step();
    in_req = '0;
    step();
    chk_val("req029_ej_valid", 32'(ejq_v), 32'd1);
    chk_val("req029_ej_addr", ejq_ad, 32'h0200_0010);
    chk_val("req029_ring_valid", 32'(rqo_v), 32'd0);

    // Foreign request passes through untouched
    in_req = mk(1'b1, 10'h155, RD, 32'h0300_0010, 32'h1234_5678);
    step();
    in_req = '0;
    step();
    chk_val("req030_ring_valid", 32'(rqo_v), 32'd1);
    chk_val("req030_ring_addr", rqo_ad, 32'h0300_0010);
    chk_val("req030_ej_valid", 32'(ejq_v), 32'd0);
    step();

    // Saturated request ring: five pushes, four accepted, one free slot drains one
    in_req = mk(1'b1, 10'h001, RD, 32'h0500_0000, 32'h0);
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      in_req = mk(1'b1, 10'h001, RD, 32'h0500_0000 + 32'(i), 32'(i));
      core_req = mk(1'b1, 10'h008, WR, 32'h0900_0000 + 32'(i), 32'hC0DE_0000 + 32'(i));
      step();
    end
    chk_val("req031_ready_full", 32'(core_rdy), 32'd0);
    core_req = '0;
    in_req = '0;
    step();
    chk_val("req031_ready_freed", 32'(core_rdy), 32'd1);
    in_req = mk(1'b1, 10'h001, RD, 32'h0500_0099, 32'h99);
    step();
    chk_val("req031_inj_valid", 32'(rqo_v), 32'd1);
    chk_val("req031_inj_data", rqo_dt, 32'hC0DE_0000);
    in_req = '0;
    repeat (6) step();

    // Ejected response frees a slot that the pending target response takes
    in_rsp = mk(1'b1, {8'h07, 2'd0}, RD_RSP, 32'h0700_0000, 32'h0);
    step();
    tgt_rsp = mk(1'b1, {8'h05, 2'd1}, WR_RSP, 32'h0000_0011, 32'h7777_0001);
    step();
    tgt_rsp = '0;
    step();
    in_rsp = mk(1'b1, {8'd2, 2'd3}, RD_RSP, 32'h0200_0044, 32'hABCD_1234);
    step();
    in_rsp = mk(1'b1, {8'h07, 2'd0}, RD_RSP, 32'h0700_0004, 32'h4);
    step();
    chk_val("req032_ej_valid", 32'(ejs_v), 32'd1);
    chk_val("req032_ej_data", ejs_dt, 32'hABCD_1234);
    chk_val("req032_inj_valid", 32'(rso_v), 32'd1);
    chk_val("req032_inj_data", rso_dt, 32'h7777_0001);
    in_rsp = '0;
    repeat (3) step();

    // Reset with three queued entries and live ring traffic
    in_req = mk(1'b1, 10'h001, RD, 32'h0600_0000, 32'h6);
    step();
    for (int i = 0; i < 3; i++) begin
      core_req = mk(1'b1, 10'h00C, WR, 32'h0A00_0000 + 32'(i), 32'hBAD0_0000 + 32'(i));
      step();
    end
    apply_reset();
    chk_val("req033_ring_valid_rst", 32'(rqo_v), 32'd0);
    chk_val("req033_ready_rst", 32'(core_rdy), 32'd0);
    for (int i = 0; i < 6; i++) begin
      step();
      chk_val("req033_no_leak", 32'(rqo_v), 32'd0);
    end

    // Randomized traffic at moderate and heavy ring load
    for (int i = 0; i < 600; i++) begin
      int unsigned pct;
      pct = (i < 300) ? 50 : 90;
      in_req = rand_slot(1'b0, pct);
      in_rsp = rand_slot(1'b1, pct);
      core_req = rand_slot(1'b0, 60);
      tgt_rsp = rand_slot(1'b1, 60);
      step();
    end
    in_req = '0; in_rsp = '0; core_req = '0; tgt_rsp = '0;
    repeat (DEPTH + 4) step();

`ifdef RING_STOP_PERF_EN
    apply_reset();
    chk_val("perf_fwd_rst", 32'(perf_fwd), 32'd0);
    in_req = mk(1'b1, 10'h001, RD, 32'h0500_0000, 32'h1);
    in_rsp = mk(1'b1, {8'h07, 2'd0}, RD_RSP, 32'h0700_0000, 32'h2);
    repeat (35000) step();
    chk_val("perf_fwd_sat", 32'(perf_fwd), 32'h0000_FFFF);
    chk_val("perf_inj_zero", 32'(perf_inj), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
